// File: rtl/pair_det_pkg.sv
// ============================================================================
// Module  : pair_det_pkg
// Brief   : Shared state encodings and round-robin helper for pair_det_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pair_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S_NONE = 2'b00,
    S_ONE  = 2'b01,
    S_ZERO = 2'b10
  } det_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pair_detect_core.sv
// ============================================================================
// Module  : pair_detect_core
// Brief   : Serial Mealy equal-pair detector; PAIR_OVERLAP_EN keeps state on match.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pair_detect_core
  import pair_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  det_state_t r_state;
  det_state_t w_next;
  logic       w_hit;

  always_comb begin
    w_hit  = 1'b0;
    w_next = r_state;
    case (r_state)
      S_ONE:   w_hit = bit_in;
      S_ZERO:  w_hit = ~bit_in;
      default: w_hit = 1'b0;
    endcase
    if (en) begin
      // The unused 2'b11 encoding falls back to S_NONE.
      if (r_state != S_NONE && r_state != S_ONE && r_state != S_ZERO) begin
        w_next = S_NONE;
      end else if (w_hit) begin
`ifdef PAIR_OVERLAP_EN
        w_next = r_state;
`else
        w_next = S_NONE;
`endif
      end else begin
        w_next = bit_in ? S_ONE : S_ZERO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= S_NONE;
    end else begin
      r_state <= w_next;
    end
  end

  assign match = en & w_hit;

endmodule

`default_nettype wire

// File: rtl/pair_det_arbiter.sv
// ============================================================================
// Module  : pair_det_arbiter
// Brief   : Round-robin sharing of one serial pair detector (option: PAIR_OVERLAP_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pair_det_arbiter
  import pair_det_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      data,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic [$clog2(WIDTH+1)-1:0] match_cnt
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BIT_W = $clog2(WIDTH);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_next;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  w_gnt_oh;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_sel_word;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_pick;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start;
  logic             w_en;
  logic             w_match;
  int               w_idx;

  assign w_start = (r_state == IDLE) && (|req);
  assign w_en    = (r_state == SHIFT);

  // Walk from the highest offset down so the last hit is the one nearest r_ptr.
  always_comb begin
    w_pick = '0;
    w_idx  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx -= NREQ;
      if (req[w_idx[ID_W-1:0]]) w_pick = w_idx[ID_W-1:0];
    end
  end

  always_comb begin
    w_sel_word       = '0;
    w_gnt_oh         = '0;
    w_gnt_oh[w_pick] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == ID_W'(i)) w_sel_word = data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_next = SHIFT;
      SHIFT:   if (r_bit_cnt == BIT_W'(WIDTH - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_word    <= '0;
      r_id      <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt     <= w_gnt_oh;
            r_word    <= w_sel_word;
            r_id      <= w_pick;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_ptr     <= ID_W'(rr_next(int'(w_pick), NREQ));
          end
        end
        SHIFT: begin
          r_word    <= {r_word[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (w_match) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  pair_detect_core u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_start),
    .en     (w_en),
    .bit_in (r_word[WIDTH-1]),
    .match  (w_match)
  );

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign done_id   = r_id;
  assign match_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pair_det_arbiter.sv
// ============================================================================
// Module  : tb_pair_det_arbiter
// Brief   : Vector table plus scoreboard bench for pair_det_arbiter (PAIR_OVERLAP_EN aware).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pair_det_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef PAIR_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [1:0]            done_id;
  logic [3:0]            match_cnt;

  typedef struct {
    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] word;
    int               id;
    int               exp_cnt;
  } vec_t;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;
  int   cyc      = 0;

  pair_det_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference pair counter: scans MSB first, remembers the last unpaired bit.
  function automatic int model(input logic [WIDTH-1:0] w, input bit ov);
    int   c    = 0;
    bit   have = 1'b0;
    logic p    = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (have && w[i] == p) begin
        c++;
        have = ov;
      end else begin
        have = 1'b1;
      end
      p = w[i];
    end
    return c;
  endfunction

  task automatic push_exp(input int id, input int cnt);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      n_done <= n_done + 1;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_id", done_id, e.id);
        check("match_cnt", match_cnt, e.cnt);
        check("gnt_at_done", gnt, 32'(1 << e.id));
      end
    end
  end

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (gnt == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (gnt == '0) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    @(negedge clk);
    req = v.req;
    data[v.id*WIDTH +: WIDTH] = v.word;
    push_exp(v.id, v.exp_cnt);
    wait_gnt(4);
    check("grant", gnt, 32'(1 << v.id));
    check("busy_in_job", busy, 1);
    req = '0;
    data[v.id*WIDTH +: WIDTH] = ~v.word;
    wait_done(WIDTH + 4);
    @(negedge clk);
    check("idle_gnt", gnt, 0);
    check("idle_busy", busy, 0);
    check("done_pulse_width", done, 0);
  endtask

  initial begin
    int g_prev;
    int nd0;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_match_cnt", match_cnt, 0);
    rst = 1'b0;

    vt[0] = '{req: 4'b0001, word: 8'hFF,       id: 0, exp_cnt: OV ? 7 : 4};
    vt[1] = '{req: 4'b0010, word: 8'b01010101, id: 1, exp_cnt: 0};
    vt[2] = '{req: 4'b0001, word: 8'b00011000, id: 0, exp_cnt: OV ? 5 : 3};
    vt[3] = '{req: 4'b1001, word: 8'b11001100, id: 3, exp_cnt: 4};
    vt[4] = '{req: 4'b0110, word: 8'b11100111, id: 1, exp_cnt: OV ? 5 : 3};
    for (int i = 5; i < 8; i++) begin
      vt[i].id      = int'($urandom_range(0, NREQ - 1));
      vt[i].req     = 4'(1 << vt[i].id);
      vt[i].word    = 8'($urandom);
      vt[i].exp_cnt = model(vt[i].word, OV);
    end
    for (int i = 0; i < 8; i++) run_job(vt[i]);

    // Held all-request round robin from a fresh pointer.
    do_reset();
    @(negedge clk);
    req    = 4'b1111;
    data   = '0;
    g_prev = 0;
    for (int j = 0; j < 5; j++) begin
      for (int n = 0; n < WIDTH + 4 && gnt != '0; n++) @(negedge clk);
      wait_gnt(4);
      check("rr_grant", gnt, 32'(1 << (j % NREQ)));
      if (j > 0) check("rr_spacing", cyc - g_prev, WIDTH + 2);
      g_prev = cyc;
      push_exp(j % NREQ, OV ? 7 : 4);
      if (j == 4) req = '0;
    end
    wait_done(WIDTH + 4);
    @(negedge clk);

    // Reset in the middle of SHIFT aborts the job silently.
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    data[0 +: WIDTH] = 8'hFF;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    req = '0;
    nd0 = n_done;
    @(negedge clk);
    check("abort_gnt", gnt, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_match_cnt", match_cnt, 0);
    rst = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    check("abort_no_done", n_done - nd0, 0);
    run_job('{req: 4'b0100, word: 8'h3C, id: 2, exp_cnt: model(8'h3C, OV)});

    // Continuously held single request; data change mid-job is ignored.
    @(negedge clk);
    req = 4'b0100;
    data[2*WIDTH +: WIDTH] = 8'hFF;
    push_exp(2, OV ? 7 : 4);
    wait_gnt(4);
    g_prev = cyc;
    repeat (3) @(negedge clk);
    data[2*WIDTH +: WIDTH] = 8'b01010101;
    wait_done(WIDTH + 4);
    check("held_done_cycle", cyc - g_prev, WIDTH);
    @(negedge clk);
    check("held_gnt_drop", gnt, 0);
    push_exp(2, model(8'b01010101, OV));
    @(negedge clk);
    check("held_regrant", gnt, 32'(4'b0100));
    req = '0;
    wait_done(WIDTH + 4);
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
